// File: rtl/vga_write_arbiter_pkg.sv
// Shared screen geometry, colour constants and arbiter state encoding for the
// VGA pixel-write path.
package vga_write_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

  function automatic logic in_screen(input logic [7:0] px, input logic [6:0] py,
                                     input int w, input int h);
    return (int'(px) < w) && (int'(py) < h);
  endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request after ptr,
// wrapping around, and returns it both one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path through
    // this block can leave a value unassigned and infer a latch.
    onehot = '0;
    idx    = '0;
    any    = |req;
    // Walk from furthest to nearest so the nearest set bit after ptr wins.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter pixel-write port between sprite drawers with
// burst-locked round-robin grants, and owns the full-screen clear sweep.
module vga_write_arbiter
  import vga_write_arbiter_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         SCREEN_W     = vga_write_arbiter_pkg::SCREEN_W,
  parameter int         SCREEN_H     = vga_write_arbiter_pkg::SCREEN_H,
  parameter int         MAX_BURST    = 16,
  parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   pix_valid,
  input  logic [NUM_REQ-1:0]   pix_last,
  input  logic [8*NUM_REQ-1:0] pix_x,
  input  logic [7*NUM_REQ-1:0] pix_y,
  input  logic [3*NUM_REQ-1:0] pix_colour,
  input  logic                 clear_req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 writeEn
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [BW-1:0]      burst_cnt;
  logic               clear_pend;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [7:0]         sel_x;
  logic [6:0]         sel_y;
  logic [2:0]         sel_colour;
  logic               accept;
  logic               in_range;
  logic               release_now;
  logic               sweep_end;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // rr_ptr holds the current winner while a grant is live, so it also selects
  // the granted requester's pixel lanes.
  always_comb begin
    sel_x       = pix_x[8*rr_ptr +: 8];
    sel_y       = pix_y[7*rr_ptr +: 7];
    sel_colour  = pix_colour[3*rr_ptr +: 3];
    accept      = gnt[rr_ptr] & pix_valid[rr_ptr];
    in_range    = in_screen(sel_x, sel_y, SCREEN_W, SCREEN_H);
    release_now = (accept && pix_last[rr_ptr]) || !req[rr_ptr] ||
                  (accept && (burst_cnt == BW'(MAX_BURST - 1)));
    sweep_end   = (x == 8'(SCREEN_W - 1)) && (y == 7'(SCREEN_H - 1));
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      clear_pend <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      writeEn    <= 1'b0;
    end else begin
      writeEn    <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req || clear_pend) begin
            // The sweep position lives directly in the x/y output registers.
            state      <= CLEAR;
            clear_pend <= 1'b0;
            clear_busy <= 1'b1;
            x          <= '0;
            y          <= '0;
            colour     <= CLEAR_COLOUR;
            writeEn    <= 1'b1;
          end else if (pick_any) begin
            state     <= GRANT;
            gnt       <= pick_onehot;
            rr_ptr    <= pick_idx;
            burst_cnt <= '0;
          end
        end

        GRANT: begin
          if (clear_req) clear_pend <= 1'b1;
          if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
            if (in_range) begin
              x       <= sel_x;
              y       <= sel_y;
              colour  <= sel_colour;
              writeEn <= 1'b1;
            end
          end
          if (release_now) begin
            state <= IDLE;
            gnt   <= '0;
          end
        end

        CLEAR: begin
          if (sweep_end) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            writeEn <= 1'b1;
            if (x == 8'(SCREEN_W - 1)) begin
              x <= '0;
              y <= y + 7'd1;
            end else begin
              x <= x + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge CLOCK_50) disable iff (!resetn)
    $onehot0(gnt));
  a_gnt_vs_clear: assert property (@(posedge CLOCK_50) disable iff (!resetn)
    !((|gnt) && clear_busy));
  a_write_in_range: assert property (@(posedge CLOCK_50) disable iff (!resetn)
    writeEn |-> in_screen(x, y, SCREEN_W, SCREEN_H));

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: directed scenarios plus random
// sprite traffic, compared each cycle against a transaction-level model.
module tb_vga_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int MB = 16;

  logic           CLOCK_50   = 1'b0;
  logic           resetn     = 1'b1;
  logic [N-1:0]   req        = '0;
  logic [N-1:0]   pix_valid  = '0;
  logic [N-1:0]   pix_last   = '0;
  logic [8*N-1:0] pix_x      = '0;
  logic [7*N-1:0] pix_y      = '0;
  logic [3*N-1:0] pix_colour = '0;
  logic           clear_req  = 1'b0;
  logic [N-1:0]   gnt;
  logic           clear_busy, clear_done, writeEn;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  vga_write_arbiter #(
    .NUM_REQ(N), .SCREEN_W(W), .SCREEN_H(H), .MAX_BURST(MB), .CLEAR_COLOUR(3'b000)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .clear_req(clear_req), .gnt(gnt), .clear_busy(clear_busy),
    .clear_done(clear_done), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: owner index (-1 = none), sweep as a linear pixel index.
  int m_owner, m_last, m_burst, m_k, m_x, m_y, m_c;
  bit m_clear, m_pend, m_done, m_we;

  // Sprite agents: each requester walks a horizontal run of pixels.
  int s_len[N], s_pos[N], s_bx[N], s_by[N];
  bit s_nolast[N], s_loop[N];
  int s_rate;
  bit manual;
  logic [N-1:0] last_acc, prev_gnt;
  int grant_log[$];

  function automatic int rr_next(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_burst = 0; m_k = 0;
    m_x = 0; m_y = 0; m_c = 0;
    m_clear = 0; m_pend = 0; m_done = 0; m_we = 0;
  endtask

  task automatic model_step();
    int o;
    m_we = 0;
    m_done = 0;
    if (m_clear) begin
      m_k++;
      if (m_k == W * H) begin
        m_clear = 0;
        m_done  = 1;
      end else begin
        m_we = 1;
        m_x  = m_k % W;
        m_y  = m_k / W;
      end
    end else if (m_owner >= 0) begin
      o = m_owner;
      if (clear_req) m_pend = 1;
      if (pix_valid[o]) begin
        m_burst++;
        if (pix_x[8*o +: 8] < W && pix_y[7*o +: 7] < H) begin
          m_we = 1;
          m_x  = pix_x[8*o +: 8];
          m_y  = pix_y[7*o +: 7];
          m_c  = pix_colour[3*o +: 3];
        end
      end
      if ((pix_valid[o] && (pix_last[o] || m_burst == MB)) || !req[o]) m_owner = -1;
    end else begin
      if (clear_req || m_pend) begin
        m_clear = 1; m_pend = 0; m_k = 0;
        m_we = 1; m_x = 0; m_y = 0; m_c = 0;
      end else if (req != '0) begin
        m_owner = rr_next(req, m_last);
        m_last  = m_owner;
        m_burst = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
    check("clear_busy", clear_busy, m_clear);
    check("clear_done", clear_done, m_done);
    check("writeEn", writeEn, m_we);
    check("x", x, m_x);
    check("y", y, m_y);
    check("colour", colour, m_c);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]               = (s_pos[i] < s_len[i]);
      pix_valid[i]         = (s_pos[i] < s_len[i]) && ($urandom_range(99) < s_rate);
      pix_x[8*i +: 8]      = 8'(s_bx[i] + s_pos[i]);
      pix_y[7*i +: 7]      = 7'(s_by[i]);
      pix_colour[3*i +: 3] = 3'($urandom);
      pix_last[i]          = (s_pos[i] < s_len[i]) && !s_nolast[i] &&
                             (s_pos[i] == s_len[i] - 1);
    end
  endtask

  // One clock: drive, predict, wait for the falling edge, then compare.
  task automatic cycle();
    if (!manual) drive();
    model_step();
    last_acc = gnt & pix_valid;
    prev_gnt = gnt;
    @(negedge CLOCK_50);
    for (int i = 0; i < N; i++) begin
      if (last_acc[i]) begin
        s_pos[i]++;
        if (s_loop[i] && s_pos[i] >= s_len[i]) s_pos[i] = 0;
      end
    end
    if (prev_gnt == '0 && gnt != '0)
      for (int i = 0; i < N; i++) if (gnt[i]) grant_log.push_back(i);
    check_outputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_writeEn", writeEn, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    model_reset();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 0; s_pos[i] = 0; s_bx[i] = 0; s_by[i] = 0;
      s_nolast[i] = 0; s_loop[i] = 0;
    end
    s_rate = 100; manual = 0; clear_req = 1'b0;
    req = '0; pix_valid = '0; pix_last = '0;
    grant_log.delete();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    check_outputs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr, dn, cnt, dead;
    bit seen2, dropped, got3, hit;

    #1;
    do_reset();

    // Single requester, three pixels with last on the third.
    s_len[1] = 3; s_bx[1] = 80; s_by[1] = 60;
    cycle();
    check("t1_gnt", gnt, 4'b0010);
    wr = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (writeEn) wr++;
    end
    check("t1_writes", wr, 3);
    check("t1_sprite_done", s_pos[1], 3);

    // Round robin with all four requesting one-pixel sprites.
    do_reset();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 1; s_loop[i] = 1; s_bx[i] = 10 * i; s_by[i] = i;
    end
    for (int c = 0; c < 40; c++) cycle();
    check("t2_grant_count", grant_log.size() >= 12, 1);
    for (int j = 0; j < 12 && j < grant_log.size(); j++)
      check("t2_order", grant_log[j], j % N);

    // Burst limit on requester 2, requester 3 waiting.
    do_reset();
    s_len[2] = 40; s_nolast[2] = 1; s_bx[2] = 10; s_by[2] = 20;
    s_len[3] = 1;  s_bx[3] = 50;    s_by[3] = 50;
    cnt = 0; dead = 0; seen2 = 0; dropped = 0; got3 = 0;
    for (int c = 0; c < 60 && !got3; c++) begin
      cycle();
      if (last_acc[2] && !dropped) cnt++;
      if (seen2 && !dropped && !gnt[2]) dropped = 1;
      if (gnt[2]) seen2 = 1;
      if (dropped && !got3) begin
        if (gnt == '0) dead++;
        else begin
          got3 = 1;
          check("t3_next_gnt", gnt, 4'b1000);
        end
      end
    end
    check("t3_burst_len", cnt, MB);
    check("t3_dead_cycles", dead, 1);
    check("t3_next_seen", got3, 1);

    // Clear requested mid-burst; requester 1 waits behind the sweep.
    do_reset();
    s_len[0] = 10; s_bx[0] = 30;  s_by[0] = 40;
    s_len[1] = 3;  s_bx[1] = 100; s_by[1] = 100;
    for (int c = 0; c < 30 && !(gnt[0] && s_pos[0] >= 3); c++) cycle();
    check("t4_mid_burst", gnt[0] && s_pos[0] >= 3, 1);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    wr = 0; dn = 0;
    for (int c = 0; c < 20100 && !(dn > 0 && s_pos[1] >= 3); c++) begin
      clear_req = (wr == 5000);
      cycle();
      if (clear_busy && writeEn) wr++;
      if (clear_done) dn++;
    end
    clear_req = 1'b0;
    check("t4_sweep_writes", wr, W * H);
    check("t4_done_pulses", dn, 1);
    check("t4_burst_finished", s_pos[0], 10);
    check("t4_req1_served", s_pos[1], 3);

    // Out-of-range pixels, release on last together with a request drop.
    do_reset();
    manual = 1;
    req = 4'b0010;
    cycle();
    check("t5_gnt", gnt, 4'b0010);
    wr = 0;
    pix_valid = 4'b0010; pix_x[15:8] = 8'd160; pix_y[13:7] = 7'd5; pix_colour[5:3] = 3'b101;
    cycle();
    if (writeEn) wr++;
    pix_x[15:8] = 8'd5; pix_y[13:7] = 7'd120; pix_last = 4'b0010; req = '0;
    cycle();
    if (writeEn) wr++;
    pix_valid = '0; pix_last = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (writeEn) wr++;
    end
    check("t5_writes", wr, 0);
    check("t5_grant_count", grant_log.size(), 1);
    check("t5_gnt_end", gnt, 0);

    // Reset in the middle of a sweep at (40,30).
    do_reset();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    hit = 0;
    for (int c = 0; c < 6000 && !hit; c++) begin
      cycle();
      if (writeEn && x == 8'd40 && y == 7'd30) hit = 1;
    end
    check("t6_sweep_reached", hit, 1);
    #2;
    do_reset();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 1; s_bx[i] = 20 + i; s_by[i] = 7;
    end
    for (int c = 0; c < 10; c++) cycle();
    check("t6_clear_first_any", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) check("t6_clear_first", grant_log[0], 0);

    // Reset in the middle of a grant.
    do_reset();
    s_len[2] = 30; s_nolast[2] = 1; s_bx[2] = 0; s_by[2] = 0;
    for (int c = 0; c < 5; c++) cycle();
    check("t6_in_grant", gnt, 4'b0100);
    #2;
    do_reset();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 1; s_bx[i] = 60 + i; s_by[i] = 9;
    end
    for (int c = 0; c < 10; c++) cycle();
    check("t6_grant_first_any", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) check("t6_grant_first", grant_log[0], 0);

    // Random sprite traffic, including off-screen runs and early drops.
    do_reset();
    s_rate = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (s_pos[i] >= s_len[i]) begin
          if ($urandom_range(9) == 0) begin
            s_pos[i]    = 0;
            s_len[i]    = $urandom_range(20, 1);
            s_bx[i]     = $urandom_range(170, 0);
            s_by[i]     = $urandom_range(127, 0);
            s_nolast[i] = ($urandom_range(19) == 0);
          end
        end else if ($urandom_range(49) == 0) begin
          s_len[i] = s_pos[i];
        end
      end
      cycle();
    end
    check("rnd_grant_activity", grant_log.size() > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
